// File: rtl/sq_window_fetcher.sv
// sq_window_fetcher
//   Read-side client of the squared-integral-image cache. A start request
//   walks a WIN_ROWS x WIN_BLKS window of blocks (block-major within a row).
//   It issues one cache read per cycle and absorbs the 1-cycle read latency.
//   Each block is emitted as a valid/ready beat.
//   Beat storage is an output register (the FIFO head) backed by a 2-entry
//   skid FIFO. Issue is throttled so that every read already in the pipe
//   always has a slot, even if the consumer stalls at any moment.
//
// Optional feature macro: SQ_FETCH_SUM_EN
//   When defined, adds o_out_sum, the unsigned sum of the WORDS words of each
//   block. The sum is computed at push time and travels with the beat.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_start                   begin a window fetch (sampled only in IDLE)
//   i_win_y, i_win_xblk       first row / first block of the window
//   o_busy, o_done            fetch in progress / one-cycle completion pulse
//   o_raddrY, o_raddrXBlock   cache read address (registered)
//   i_rq                      cache read data, valid one cycle after address
//   o_out_valid, i_out_ready  output beat handshake
//   o_out_data, o_out_row, o_out_blk, o_out_last   beat payload and tags
//   o_out_sum                 block word sum (SQ_FETCH_SUM_EN only)
module sq_window_fetcher #(
  parameter int WORD_SIZE = 32,
  parameter int WORDS     = 8,
  parameter int ROWS      = 32,
  parameter int BLOCKS    = 4,
  parameter int Y_WIDTH   = $clog2(ROWS),
  parameter int XB_WIDTH  = $clog2(BLOCKS),
  parameter int WIN_ROWS  = 4,
  parameter int WIN_BLKS  = 2
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [Y_WIDTH-1:0]            i_win_y,
  input  logic [XB_WIDTH-1:0]           i_win_xblk,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [Y_WIDTH-1:0]            o_raddrY,
  output logic [XB_WIDTH-1:0]           o_raddrXBlock,
  input  logic [WORDS*WORD_SIZE-1:0]    i_rq,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [WORDS*WORD_SIZE-1:0]    o_out_data,
  output logic [$clog2(WIN_ROWS):0]     o_out_row,
  output logic [$clog2(WIN_BLKS):0]     o_out_blk,
`ifdef SQ_FETCH_SUM_EN
  output logic [WORD_SIZE+$clog2(WORDS)-1:0] o_out_sum,
`endif
  output logic                          o_out_last
);

  localparam int DW = WORDS * WORD_SIZE;
  localparam int RW = $clog2(WIN_ROWS) + 1;
  localparam int BW = $clog2(WIN_BLKS) + 1;
  localparam int YS = Y_WIDTH + 1;
  localparam int XS = XB_WIDTH + 1;
`ifdef SQ_FETCH_SUM_EN
  localparam int SUM_W = WORD_SIZE + $clog2(WORDS);
`else
  localparam int SUM_W = 0;
`endif
  // Beat entry layout: {sum, last, blk, row, data}
  localparam int EW = DW + RW + BW + 1 + SUM_W;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

`ifdef SQ_FETCH_SUM_EN
  function automatic logic [SUM_W-1:0] block_sum(input logic [DW-1:0] d);
    logic [SUM_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < WORDS; i++) begin
      acc = acc + SUM_W'(d[i*WORD_SIZE +: WORD_SIZE]);
    end
    return acc;
  endfunction
`else
`endif

  state_t                r_state;
  logic [Y_WIDTH-1:0]    r_win_y;
  logic [XB_WIDTH-1:0]   r_win_xblk;
  logic [RW-1:0]         r_row;
  logic [BW-1:0]         r_blk;
  logic                  r_busy, r_done;
  logic [Y_WIDTH-1:0]    r_raddr_y;
  logic [XB_WIDTH-1:0]   r_raddr_x;
  // Stage a: address on the cache port this cycle. Stage b: its data on i_rq.
  logic                  r_a_valid, r_a_last, r_b_valid, r_b_last;
  logic [RW-1:0]         r_a_row, r_b_row;
  logic [BW-1:0]         r_a_blk, r_b_blk;
  logic                  r_out_valid;
  logic [EW-1:0]         r_out_entry;
  logic [EW-1:0]         r_sk [0:1];
  logic [1:0]            r_sk_cnt;

  logic                  w_pop, w_take, w_first, w_issue, w_is_last, w_drained;
  logic [2:0]            w_occ;
  logic [RW-1:0]         w_cur_row, w_nxt_row;
  logic [BW-1:0]         w_cur_blk, w_nxt_blk;
  logic [Y_WIDTH-1:0]    w_base_y, w_y_next;
  logic [XB_WIDTH-1:0]   w_base_x, w_x_next;
  logic [YS-1:0]         w_y_sum;
  logic [XS-1:0]         w_x_sum;
  logic [EW-1:0]         w_in_entry;

  assign w_pop  = r_out_valid & i_out_ready;
  assign w_take = ~r_out_valid | w_pop;
  // Everything already committed to storage: head, skid entries, both read stages.
  assign w_occ  = 3'(r_out_valid) + 3'(r_sk_cnt) + 3'(r_a_valid) + 3'(r_b_valid) - 3'(w_pop);
  // The accepting start edge issues the first read so its address shows up in cycle 1.
  assign w_first = (r_state == S_IDLE) && i_start;
  assign w_issue = w_first || ((r_state == S_FETCH) && (w_occ < 3'd3));
  assign w_drained = ~r_a_valid & ~r_b_valid & (r_sk_cnt == 2'd0) & w_pop
                     & r_out_entry[DW+RW+BW];

  // Select the coordinates of the read that would issue this cycle and wrap the address.
  always_comb begin
    w_cur_row = r_row;
    w_cur_blk = r_blk;
    w_base_y  = r_win_y;
    w_base_x  = r_win_xblk;
    if (w_first) begin
      w_cur_row = '0;
      w_cur_blk = '0;
      w_base_y  = i_win_y;
      w_base_x  = i_win_xblk;
    end else begin
      w_cur_row = r_row;
      w_cur_blk = r_blk;
    end
    w_is_last = (w_cur_row == RW'(WIN_ROWS - 1)) && (w_cur_blk == BW'(WIN_BLKS - 1));
    if (w_cur_blk == BW'(WIN_BLKS - 1)) begin
      w_nxt_blk = '0;
      w_nxt_row = w_cur_row + RW'(1);
    end else begin
      w_nxt_blk = w_cur_blk + BW'(1);
      w_nxt_row = w_cur_row;
    end
    // Both operands are below the modulus, so one conditional subtract wraps.
    w_y_sum = YS'(w_base_y) + YS'(w_cur_row);
    w_x_sum = XS'(w_base_x) + XS'(w_cur_blk);
    if (w_y_sum >= YS'(ROWS)) begin
      w_y_next = Y_WIDTH'(w_y_sum - YS'(ROWS));
    end else begin
      w_y_next = Y_WIDTH'(w_y_sum);
    end
    if (w_x_sum >= XS'(BLOCKS)) begin
      w_x_next = XB_WIDTH'(w_x_sum - XS'(BLOCKS));
    end else begin
      w_x_next = XB_WIDTH'(w_x_sum);
    end
  end

  // Pack the returning cache data with the tags of the read that produced it.
  always_comb begin
    w_in_entry = '0;
    w_in_entry[DW-1:0]         = i_rq;
    w_in_entry[DW +: RW]       = r_b_row;
    w_in_entry[DW+RW +: BW]    = r_b_blk;
    w_in_entry[DW+RW+BW]       = r_b_last;
`ifdef SQ_FETCH_SUM_EN
    w_in_entry[DW+RW+BW+1 +: SUM_W] = block_sum(i_rq);
`else
`endif
  end

  // Control FSM, window counters, read address and read-latency pipeline.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_win_y    <= '0;
      r_win_xblk <= '0;
      r_row      <= '0;
      r_blk      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_raddr_y  <= '0;
      r_raddr_x  <= '0;
      r_a_valid  <= 1'b0;
      r_a_row    <= '0;
      r_a_blk    <= '0;
      r_a_last   <= 1'b0;
      r_b_valid  <= 1'b0;
      r_b_row    <= '0;
      r_b_blk    <= '0;
      r_b_last   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_a_valid <= w_issue;
      r_a_row   <= w_cur_row;
      r_a_blk   <= w_cur_blk;
      r_a_last  <= w_is_last;
      r_b_valid <= r_a_valid;
      r_b_row   <= r_a_row;
      r_b_blk   <= r_a_blk;
      r_b_last  <= r_a_last;
      if (w_issue) begin
        r_raddr_y <= w_y_next;
        r_raddr_x <= w_x_next;
        r_row     <= w_nxt_row;
        r_blk     <= w_nxt_blk;
      end
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_win_y    <= i_win_y;
            r_win_xblk <= i_win_xblk;
            r_busy     <= 1'b1;
            r_state    <= w_is_last ? S_DRAIN : S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_issue && w_is_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_drained) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output head register plus 2-entry skid FIFO; the head refills from the
  // skid first, otherwise straight from the returning read.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_out_entry <= '0;
      r_sk[0]     <= '0;
      r_sk[1]     <= '0;
      r_sk_cnt    <= 2'd0;
    end else if (w_take) begin
      if (r_sk_cnt != 2'd0) begin
        r_out_valid <= 1'b1;
        r_out_entry <= r_sk[0];
        r_sk[0]     <= r_sk[1];
        if (r_b_valid) begin
          if (r_sk_cnt == 2'd1) begin
            r_sk[0] <= w_in_entry;
          end else begin
            r_sk[1] <= w_in_entry;
          end
        end
        r_sk_cnt <= r_sk_cnt - 2'd1 + 2'(r_b_valid);
      end else if (r_b_valid) begin
        r_out_valid <= 1'b1;
        r_out_entry <= w_in_entry;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (r_b_valid) begin
      if (r_sk_cnt == 2'd0) begin
        r_sk[0] <= w_in_entry;
      end else begin
        r_sk[1] <= w_in_entry;
      end
      r_sk_cnt <= r_sk_cnt + 2'd1;
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_raddrY      = r_raddr_y;
  assign o_raddrXBlock = r_raddr_x;
  assign o_out_valid   = r_out_valid;
  assign o_out_data    = r_out_entry[DW-1:0];
  assign o_out_row     = r_out_entry[DW +: RW];
  assign o_out_blk     = r_out_entry[DW+RW +: BW];
  assign o_out_last    = r_out_entry[DW+RW+BW];
`ifdef SQ_FETCH_SUM_EN
  assign o_out_sum     = r_out_entry[DW+RW+BW+1 +: SUM_W];
`else
`endif

endmodule

// File: doc/sq_window_fetcher.md
# sq_window_fetcher

Read-side client of the squared-integral-image cache. On `start` it walks a window of `WIN_ROWS` × `WIN_BLKS` blocks, one block per cycle, starting at (`win_y`, `win_xblk`). It issues reads on the cache read port, absorbs the cache's 1-cycle read latency in a 2-entry skid FIFO, and emits each block as a valid/ready beat to the downstream variance/feature stage.

## Interface
Parameters:
- `WORD_SIZE`, 32: bits per cache word
- `WORDS`, 8: words per block (one cache read returns `WORDS` words)
- `ROWS`, 32: rows held in the cache; the row index wraps modulo `ROWS`
- `BLOCKS`, 4: blocks per cache row; the block index wraps modulo `BLOCKS`
- `Y_WIDTH`, `$clog2(ROWS)`: row address width
- `XB_WIDTH`, `$clog2(BLOCKS)`: block address width
- `WIN_ROWS`, 4: window height in rows, 1..`ROWS`
- `WIN_BLKS`, 2: window width in blocks, 1..`BLOCKS`

Ports:
- `clk` in 1: single clock
- `reset` in 1: synchronous, active-high
- `start` in 1: begin a window fetch; sampled only in IDLE
- `win_y` in `Y_WIDTH`: first row of the window
- `win_xblk` in `XB_WIDTH`: first block of the window
- `busy` out 1: high from the cycle after an accepted `start` until `done`
- `done` out 1: one-cycle pulse after the last beat is accepted
- `raddrY` out `Y_WIDTH`: to cache read port `raddrY`
- `raddrXBlock` out `XB_WIDTH`: to cache read port `raddrXBlock`
- `rq` in `WORDS*WORD_SIZE`: cache read data `q`, valid one cycle after the address
- `out_valid` out 1: beat available
- `out_ready` in 1: downstream accepts the beat
- `out_data` out `WORDS*WORD_SIZE`: block data, word 0 in the LSBs
- `out_row` out `$clog2(WIN_ROWS)+1`: row offset within the window
- `out_blk` out `$clog2(WIN_BLKS)+1`: block offset within the window
- `out_last` out 1: final beat of the window

## Operation
- FSM states are IDLE, FETCH, DRAIN and DONE.
  - IDLE + `start` → FETCH. In the same edge, latch `win_y`/`win_xblk` and clear the row and block counters.
  - FETCH issues one read per cycle when `fifo_cnt + inflight − pop < 2`.
  - Scan order is block-major within a row: `blk` counts 0..`WIN_BLKS`−1, then `row` increments.
  - FETCH → DRAIN on issuing read `WIN_ROWS*WIN_BLKS`−1.
  - DRAIN waits for `inflight`=0, the FIFO to be empty, and the last pop. Then → DONE.
  - DONE lasts one cycle with `done`=1, then → IDLE.
- Address generation:
  - `raddrY = (win_y + row) mod ROWS`
  - `raddrXBlock = (win_xblk + blk) mod BLOCKS`
  - Both are registered outputs. On issue cycles they hold the issued address; otherwise they hold their last value.
- `inflight` is set on an issue and cleared the next cycle. When `inflight`=1, `rq` is pushed into the FIFO together with its `row`/`blk`/`last` tags.
- FIFO: 2 entries. The head drives `out_*`. A pop occurs when `out_valid && out_ready`. The issue rule means the FIFO never overflows.
- Handshake: while `out_valid && !out_ready`, all `out_*` hold stable. `out_valid` never drops without a pop.
- `start` is ignored outside IDLE.
- `reset` mid-operation: FSM → IDLE; FIFO, `inflight` and counters clear; read data still in flight is discarded.
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `out_row`=0, `out_blk`=0, `raddrY`=0, `raddrXBlock`=0.

## Timing
- Cycle 0: `start` seen in IDLE.
- Cycle 1: first address on `raddrY`/`raddrXBlock`; `busy`=1.
- Cycle 2: cache data on `rq`, pushed into the FIFO.
- Cycle 3: first `out_valid`.
- With `out_ready` held high, beats come 1 per cycle. For N=`WIN_ROWS*WIN_BLKS`, the last beat is in cycle N+2 and `done` is in cycle N+3.
- A stall of k cycles delays `done` by exactly k cycles. Issue resumes the cycle after the first pop.

## Configuration
- `SQ_FETCH_SUM_EN` defined:
  - Adds output `out_sum` of width `WORD_SIZE+$clog2(WORDS)`: the unsigned sum of the `WORDS` words of `rq`.
  - The sum is computed at FIFO push and stored alongside the data, so it holds under stall like the other outputs.
  - Reset value is 0.
- `SQ_FETCH_SUM_EN` not defined: the port and the adder are absent; all other behaviour is identical.

## Test plan
- Reset, then `start` with `win_y`=3, `win_xblk`=1, ready high:
  - addresses (3,1),(3,2),(4,1),(4,2),(5,1),(5,2),(6,1),(6,2) on consecutive cycles;
  - data matches the cache model, `out_last` on beat 8, `done` at cycle 11.
- Wrap: `win_y`=30, `win_xblk`=3, `ROWS`=32, `BLOCKS`=4 → rows 30,31,0,1 and blocks 3,0 in order.
- Backpressure: `out_ready` low for 5 cycles at beat 2 → `out_data`/`out_row`/`out_blk` stable, no beat lost or duplicated, at most 2 reads outstanding, `done` 5 cycles late.
- `start` pulsed during FETCH → ignored; exactly 8 beats; a following `start` in IDLE produces a fresh window.
- `reset` asserted at beat 3 → next cycle all outputs at reset values; a new `start` fetches from row offset 0 with no stale beats.
- With `SQ_FETCH_SUM_EN`, words 1..8 in a block → `out_sum`=36; with a stall, `out_sum` holds.
